spatz_vreg_scoreboard: RTL
==========================

Name: spatz_vreg_scoreboard

Overview:
- Tracks vector-register hazards for up to NrInstr in-flight Spatz instructions, each identified by its spatz_id_t.
- Sits between the controller issue stage and the VRF read/write ports of VFU, VLSU and VSLDU.
- WAW and WAR hazards stall issue.
- RAW hazards are resolved per VRF word (chaining): a consumer may read word w of a register once its producer has written word w.

Parameters:
- NrInstr, 4: in-flight instruction slots; id width is clog2(NrInstr).
- NrRdPorts, 5: read ports (VFU vs2/vs1/vd, VLSU vd, VSLDU vs2).
- NrWrPorts, 3: write ports (VFU, VLSU, VSLDU).
- NrVRegs, 32: architectural vector registers; vreg width is clog2(NrVRegs).
- NrWordsPerVector, 4: VRF words per register.
- MaxLMUL, 8: maximum register-group size. Word-index width WW = clog2(MaxLMUL*NrWordsPerVector).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  new instruction offered.
- issue_ready_o  out  1  instruction accepted this cycle.
- issue_id_i  in  IDW  slot id.
- issue_vd_i, issue_vs1_i, issue_vs2_i  in  5 each  register numbers.
- issue_use_vd_i, issue_use_vs1_i, issue_use_vs2_i  in  1 each  operand-used flags.
- retire_valid_i  in  1  instruction completed.
- retire_id_i  in  IDW  completed slot.
- rd_req_i  in  NrRdPorts  per-port read request.
- rd_id_i  in  NrRdPorts×IDW  requester id.
- rd_vreg_i  in  NrRdPorts×5  register read.
- rd_word_i  in  NrRdPorts×WW  word index within the group.
- rd_gnt_o  out  NrRdPorts  read permitted.
- wr_valid_i  in  NrWrPorts  write committed.
- wr_id_i  in  NrWrPorts×IDW  writer id.
- wr_word_i  in  NrWrPorts×WW  word index written.
- busy_o  out  NrInstr  slot occupied.
- wr_err_o  out  1  protocol-error pulse.

Behaviour:
- Each slot holds a registered entry: valid, vd, use_vd, vs1, use_vs1, vs2, use_vs2, wr_cnt[WW:0].
- Reset: all entries invalid, wr_cnt=0, busy_o=0, wr_err_o=0. issue_ready_o is 0 while rst_i=1. Reset mid-operation drops all entries and nothing is retained.
- issue_ready_o is combinational from registered state. It is 1 iff rst_i=0 and all of the following hold:
  - slot issue_id_i is invalid;
  - no issue_use_vd_i match on the vd of any valid entry with use_vd (WAW);
  - no issue_use_vd_i match on the vs1/vs2 of any valid entry with the matching use flag (WAR).
- Hazard checks consider register numbers only. Register-group overlap for LMUL>1 is resolved by the controller, which issues one entry per base register.
- Accept (valid&ready): the entry is written at the clock edge with wr_cnt=0 and busy_o[id] rises next cycle. Latency issue→visible is 1 cycle.
- Retire clears the entry at the next edge.
- Retire and issue in the same cycle: issue_ready_o uses the pre-retire state, so issuing into the retiring slot is stalled one cycle. Retire of an invalid slot is ignored.
- Read grant is combinational per port. rd_gnt_o[p]=1 iff rd_req_i[p] and there is no valid entry e≠rd_id_i[p] with use_vd, vd==rd_vreg_i[p] and wr_cnt<=rd_word_i[p].
  - A requester reading its own vd is always granted.
  - A register with no producer is always granted.
- Write commit: wr_valid_i[q] with wr_word_i==wr_cnt of entry wr_id_i increments that wr_cnt at the edge, saturating at MaxLMUL*NrWordsPerVector.
  - Reads of the same word in the same cycle see the old count and are not granted; they are granted the next cycle.
- wr_err_o pulses for 1 cycle, registered, on any of:
  - a write to an invalid slot;
  - wr_word_i≠wr_cnt;
  - two ports writing the same id in one cycle.
  On an erroring write the counter is not updated; for a duplicate, the lowest-index port's write is honoured if it is otherwise legal.
- Read grants are pure functions of current state; rd_req_i is never registered.

Test Plan:
- Reset with all inputs active → issue_ready_o=0, busy_o=0, rd_gnt_o=0, wr_err_o=0. After release, issue id0 vd=v4 → busy_o=4'b0001 next cycle.
- RAW chaining: id0 vd=v4 issued, id1 reads v4 word0 → gnt=0. VFU writes id0 word0 → id1 word0 gnt=1 next cycle while word1 gnt stays 0. After 4 writes, words 0-3 are granted.
- WAW/WAR: id0 vd=v4,vs2=v8 valid. Issue id1 vd=v4 → ready=0. Issue id1 vd=v8 → ready=0. Issue id1 vd=v9 → ready=1.
- Retire/issue collision: retire id0 and issue id0 vd=v2 in the same cycle → ready=0. Next cycle ready=1 and busy_o[0]=1 holds the new entry.
- Errors:
  - write id2 (invalid) → wr_err_o=1 for one cycle;
  - id0 writing word2 with wr_cnt=0 → wr_err_o=1 and wr_cnt stays 0;
  - ports 0 and 1 both writing id0 word0 → error, wr_cnt=1.
- Mid-stream reset with 3 entries busy → busy_o=0 after the edge, and a previously blocked read of v4 is granted.

Source files
------------

// File: rtl/spatz_vreg_scoreboard.sv
// spatz_vreg_scoreboard: per-instruction vector-register hazard tracker.
// WAW/WAR stall issue; RAW is resolved per VRF word via each producer's write count.
module spatz_vreg_scoreboard #(
    parameter int unsigned NrInstr          = 4,
    parameter int unsigned NrRdPorts        = 5,
    parameter int unsigned NrWrPorts        = 3,
    parameter int unsigned NrVRegs          = 32,
    parameter int unsigned NrWordsPerVector = 4,
    parameter int unsigned MaxLMUL          = 8,
    localparam int unsigned IDW = $clog2(NrInstr),
    localparam int unsigned VW  = $clog2(NrVRegs),
    localparam int unsigned WW  = $clog2(MaxLMUL * NrWordsPerVector)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [IDW-1:0]           issue_id_i,
    input  logic [VW-1:0]            issue_vd_i,
    input  logic [VW-1:0]            issue_vs1_i,
    input  logic [VW-1:0]            issue_vs2_i,
    input  logic                     issue_use_vd_i,
    input  logic                     issue_use_vs1_i,
    input  logic                     issue_use_vs2_i,
    input  logic                     retire_valid_i,
    input  logic [IDW-1:0]           retire_id_i,
    input  logic [NrRdPorts-1:0]     rd_req_i,
    input  logic [NrRdPorts*IDW-1:0] rd_id_i,
    input  logic [NrRdPorts*VW-1:0]  rd_vreg_i,
    input  logic [NrRdPorts*WW-1:0]  rd_word_i,
    output logic [NrRdPorts-1:0]     rd_gnt_o,
    input  logic [NrWrPorts-1:0]     wr_valid_i,
    input  logic [NrWrPorts*IDW-1:0] wr_id_i,
    input  logic [NrWrPorts*WW-1:0]  wr_word_i,
    output logic [NrInstr-1:0]       busy_o,
    output logic                     wr_err_o
);
    typedef struct packed {
        logic          valid;
        logic [VW-1:0] vd;
        logic          use_vd;
        logic [VW-1:0] vs1;
        logic          use_vs1;
        logic [VW-1:0] vs2;
        logic          use_vs2;
        logic [WW:0]   wr_cnt;
    } entry_t;

    entry_t [NrInstr-1:0] ent_q, ent_d;
    logic                 wr_err_q, wr_err_d;
    logic                 hazard;
    logic [NrInstr-1:0]   claimed;
    logic [IDW-1:0]       wid;

    always_comb begin
        hazard = 1'b0;
        for (int e = 0; e < NrInstr; e++)
            if (ent_q[e].valid && issue_use_vd_i &&
                ((ent_q[e].use_vd  && ent_q[e].vd  == issue_vd_i) ||
                 (ent_q[e].use_vs1 && ent_q[e].vs1 == issue_vd_i) ||
                 (ent_q[e].use_vs2 && ent_q[e].vs2 == issue_vd_i)))
                hazard = 1'b1;
        issue_ready_o = !rst_i && !ent_q[issue_id_i].valid && !hazard;
    end

    // Word w of a producer's vd is readable once wr_cnt has moved past w.
    always_comb begin
        rd_gnt_o = '0;
        for (int p = 0; p < NrRdPorts; p++) begin
            rd_gnt_o[p] = rd_req_i[p] && !rst_i;
            for (int e = 0; e < NrInstr; e++)
                if (ent_q[e].valid && ent_q[e].use_vd &&
                    IDW'(e) != rd_id_i[p*IDW +: IDW] &&
                    ent_q[e].vd == rd_vreg_i[p*VW +: VW] &&
                    ent_q[e].wr_cnt <= {1'b0, rd_word_i[p*WW +: WW]})
                    rd_gnt_o[p] = 1'b0;
        end
    end

    always_comb begin
        ent_d    = ent_q;
        wr_err_d = 1'b0;
        claimed  = '0;
        wid      = '0;
        for (int q = 0; q < NrWrPorts; q++) begin
            wid = wr_id_i[q*IDW +: IDW];
            if (wr_valid_i[q]) begin
                // A legal write has word == wr_cnt <= 2^WW-1, so the increment never passes the maximum.
                if (!ent_q[wid].valid || claimed[wid] || ent_q[wid].wr_cnt != {1'b0, wr_word_i[q*WW +: WW]})
                    wr_err_d = 1'b1;
                else
                    ent_d[wid].wr_cnt = ent_q[wid].wr_cnt + 1'b1;
                claimed[wid] = 1'b1;
            end
        end
        if (retire_valid_i)
            ent_d[retire_id_i].valid = 1'b0;
        if (issue_valid_i && issue_ready_o)
            ent_d[issue_id_i] = '{valid: 1'b1, vd: issue_vd_i, use_vd: issue_use_vd_i,
                                  vs1: issue_vs1_i, use_vs1: issue_use_vs1_i,
                                  vs2: issue_vs2_i, use_vs2: issue_use_vs2_i, wr_cnt: '0};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            ent_q    <= ent_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int e = 0; e < NrInstr; e++)
            busy_o[e] = ent_q[e].valid;
    end

    assign wr_err_o = wr_err_q;
endmodule
